// File: rtl/filter_gen_pkg.sv
// Shared types and width helpers for the filter-buffer read-address generator.
package filter_gen_pkg;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, used to size address and configuration fields.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        while ((32'sd1 << result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

    // Default geometry and the field widths derived from it.
    localparam int DEF_DEPTH           = 32'sd16;
    localparam int DEF_MAX_FILTER_SIZE = 32'sd8;
    localparam int DEF_NUM_FILTERS_MAX = 32'sd4;
    localparam int DEF_MAX_REPEAT      = 32'sd16;
    localparam int DEF_ADDR_W          = clog2(DEF_DEPTH);
    localparam int DEF_FS_W            = clog2(DEF_MAX_FILTER_SIZE + 32'sd1);
    localparam int DEF_NF_W            = clog2(DEF_NUM_FILTERS_MAX + 32'sd1);
    localparam int DEF_RP_W            = clog2(DEF_MAX_REPEAT + 32'sd1);

endpackage

// File: rtl/filter_addr_gen_mod_add.sv
// Modular adder for a circular buffer whose depth need not be a power of two.
// Valid for i_a < DEPTH and i_b <= DEPTH, so one conditional subtract suffices.
module mod_add #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] i_a,
    input  logic [ADDR_W:0]   i_b,
    output logic [ADDR_W-1:0] o_sum
);

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W:0] w_raw;

    // Widen by one bit, add, then fold back into 0..DEPTH-1.
    always_comb begin
        w_raw = {1'b0, i_a} + i_b;
        if (w_raw >= L_DEPTH) begin
            o_sum = ADDR_W'(w_raw - L_DEPTH);
        end else begin
            o_sum = ADDR_W'(w_raw);
        end
    end

endmodule

// File: rtl/filter_addr_gen.sv
// Read-address generator for the convolution filter buffer. Walks each filter
// row by row, replays it cfg_repeat times, then advances the head around the
// circular buffer. Addresses leave on a valid/ready handshake.
module filter_addr_gen
    import filter_gen_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int MAX_FILTER_SIZE = 8,
    parameter int NUM_FILTERS_MAX = 4,
    parameter int MAX_REPEAT      = 16,
    localparam int ADDR_W         = clog2(DEPTH),
    localparam int FS_W           = clog2(MAX_FILTER_SIZE + 1),
    localparam int NF_W           = clog2(NUM_FILTERS_MAX + 1),
    localparam int RP_W           = clog2(MAX_REPEAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [FS_W-1:0]   cfg_filter_size,
    input  logic [NF_W-1:0]   cfg_num_filters,
    input  logic [RP_W-1:0]   cfg_repeat,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] raddr,
    output logic [NF_W-1:0]   filter_idx,
    output logic              last_in_filter,
    output logic              last_filter,
    output logic              busy,
    output logic              done,
    output logic              err_cfg
);

    // State and datapath registers. r_raddr always equals (r_head + r_idx)
    // mod DEPTH while running, so it is kept as its own register and the
    // outputs come straight from flops.
    state_t            r_state;
    logic [FS_W-1:0]   r_fs;
    logic [NF_W-1:0]   r_nf;
    logic [RP_W-1:0]   r_rpt;
    logic [ADDR_W-1:0] r_head;
    logic [FS_W-1:0]   r_idx;
    logic [RP_W-1:0]   r_rep;
    logic [NF_W-1:0]   r_fcnt;
    logic [ADDR_W-1:0] r_raddr;
    logic              r_addr_valid;
    logic              r_last_in_filter;
    logic              r_last_filter;
    logic              r_busy;
    logic              r_done;
    logic              r_err_cfg;

    state_t            w_state_nxt;
    logic [FS_W-1:0]   w_fs_nxt;
    logic [NF_W-1:0]   w_nf_nxt;
    logic [RP_W-1:0]   w_rpt_nxt;
    logic [ADDR_W-1:0] w_head_nxt;
    logic [FS_W-1:0]   w_idx_nxt;
    logic [RP_W-1:0]   w_rep_nxt;
    logic [NF_W-1:0]   w_fcnt_nxt;
    logic [ADDR_W-1:0] w_raddr_nxt;
    logic              w_err_nxt;
    logic              w_lif_nxt;
    logic              w_lf_nxt;

    logic              w_cfg_ok;
    logic              w_idx_last;
    logic              w_rep_last;
    logic              w_fcnt_last;
    logic [ADDR_W-1:0] w_raddr_inc;
    logic [ADDR_W-1:0] w_head_adv;
    logic [ADDR_W:0]   w_fs_ext;

    // Next row of the current pass.
    mod_add #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_add_row (
        .i_a   (r_raddr),
        .i_b   ((ADDR_W + 1)'(1'b1)),
        .o_sum (w_raddr_inc)
    );

    // Head of the next filter; fs <= DEPTH is guaranteed by the start check.
    assign w_fs_ext = (ADDR_W + 1)'(r_fs);

    mod_add #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_add_head (
        .i_a   (r_head),
        .i_b   (w_fs_ext),
        .o_sum (w_head_adv)
    );

    assign w_cfg_ok =
        (int'(cfg_filter_size) >= 32'sd1) && (int'(cfg_filter_size) <= MAX_FILTER_SIZE) &&
        (int'(cfg_num_filters) >= 32'sd1) && (int'(cfg_num_filters) <= NUM_FILTERS_MAX) &&
        (int'(cfg_repeat) >= 32'sd1)      && (int'(cfg_repeat) <= MAX_REPEAT) &&
        ((int'(cfg_filter_size) * int'(cfg_num_filters)) <= DEPTH);

    assign w_idx_last  = (r_idx  == (r_fs  - FS_W'(1'b1)));
    assign w_rep_last  = (r_rep  == (r_rpt - RP_W'(1'b1)));
    assign w_fcnt_last = (r_fcnt == (r_nf  - NF_W'(1'b1)));

    // Flags describe the address that will be presented next cycle.
    assign w_lif_nxt = (w_state_nxt == ST_RUN) && (w_idx_nxt == (w_fs_nxt - FS_W'(1'b1)));
    assign w_lf_nxt  = (w_state_nxt == ST_RUN) &&
                       (w_fcnt_nxt == (w_nf_nxt - NF_W'(1'b1))) &&
                       (w_rep_nxt == (w_rpt_nxt - RP_W'(1'b1)));

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and counter logic; abort outranks transfer and start.
    always_comb begin
        w_state_nxt = r_state;
        w_fs_nxt    = r_fs;
        w_nf_nxt    = r_nf;
        w_rpt_nxt   = r_rpt;
        w_head_nxt  = r_head;
        w_idx_nxt   = r_idx;
        w_rep_nxt   = r_rep;
        w_fcnt_nxt  = r_fcnt;
        w_raddr_nxt = r_raddr;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (start && w_cfg_ok) begin
                    w_state_nxt = ST_RUN;
                    w_fs_nxt    = cfg_filter_size;
                    w_nf_nxt    = cfg_num_filters;
                    w_rpt_nxt   = cfg_repeat;
                    w_head_nxt  = cfg_base_addr;
                    w_raddr_nxt = cfg_base_addr;
                    w_idx_nxt   = FS_W'(1'b0);
                    w_rep_nxt   = RP_W'(1'b0);
                    w_fcnt_nxt  = NF_W'(1'b0);
                end else if (start) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort || (addr_ready && w_idx_last && w_rep_last && w_fcnt_last)) begin
                    // Leaving RUN: park the pointers at zero so outputs read 0.
                    w_state_nxt = abort ? ST_IDLE : ST_DONE;
                    w_head_nxt  = ADDR_W'(1'b0);
                    w_raddr_nxt = ADDR_W'(1'b0);
                    w_idx_nxt   = FS_W'(1'b0);
                    w_rep_nxt   = RP_W'(1'b0);
                    w_fcnt_nxt  = NF_W'(1'b0);
                end else if (addr_ready && !w_idx_last) begin
                    w_idx_nxt   = r_idx + FS_W'(1'b1);
                    w_raddr_nxt = w_raddr_inc;
                end else if (addr_ready && !w_rep_last) begin
                    w_idx_nxt   = FS_W'(1'b0);
                    w_rep_nxt   = r_rep + RP_W'(1'b1);
                    w_raddr_nxt = r_head;
                end else if (addr_ready) begin
                    w_idx_nxt   = FS_W'(1'b0);
                    w_rep_nxt   = RP_W'(1'b0);
                    w_fcnt_nxt  = r_fcnt + NF_W'(1'b1);
                    w_head_nxt  = w_head_adv;
                    w_raddr_nxt = w_head_adv;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath, configuration and registered output flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fs             <= FS_W'(1'b0);
            r_nf             <= NF_W'(1'b0);
            r_rpt            <= RP_W'(1'b0);
            r_head           <= ADDR_W'(1'b0);
            r_idx            <= FS_W'(1'b0);
            r_rep            <= RP_W'(1'b0);
            r_fcnt           <= NF_W'(1'b0);
            r_raddr          <= ADDR_W'(1'b0);
            r_addr_valid     <= 1'b0;
            r_last_in_filter <= 1'b0;
            r_last_filter    <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_err_cfg        <= 1'b0;
        end else begin
            r_fs             <= w_fs_nxt;
            r_nf             <= w_nf_nxt;
            r_rpt            <= w_rpt_nxt;
            r_head           <= w_head_nxt;
            r_idx            <= w_idx_nxt;
            r_rep            <= w_rep_nxt;
            r_fcnt           <= w_fcnt_nxt;
            r_raddr          <= w_raddr_nxt;
            r_addr_valid     <= (w_state_nxt == ST_RUN);
            r_last_in_filter <= w_lif_nxt;
            r_last_filter    <= w_lf_nxt;
            r_busy           <= (w_state_nxt != ST_IDLE);
            r_done           <= (w_state_nxt == ST_DONE);
            r_err_cfg        <= w_err_nxt;
        end
    end

    assign addr_valid     = r_addr_valid;
    assign raddr          = r_raddr;
    assign filter_idx     = r_fcnt;
    assign last_in_filter = r_last_in_filter;
    assign last_filter    = r_last_filter;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err_cfg        = r_err_cfg;

endmodule

// File: tb/tb_filter_addr_gen.sv
// Scoreboard bench for filter_addr_gen: stimulus pushes hand-computed
// expected addresses, monitors pop and compare on every accepted transfer.
module tb_filter_addr_gen;

    typedef struct {
        int raddr;
        int fidx;
        int lif;
        int lf;
    } exp_t;

    logic clk;
    logic rst;

    // DEPTH=16 instance signals
    logic       start16, abort16, ready16, valid16, lif16, lf16, busy16, done16, err16;
    logic [3:0] base16, raddr16, fs16;
    logic [2:0] nf16, fidx16;
    logic [4:0] rp16;

    // DEPTH=12 instance signals
    logic       start12, abort12, ready12, valid12, lif12, lf12, busy12, done12, err12;
    logic [3:0] base12, raddr12, fs12;
    logic [2:0] nf12, fidx12;
    logic [4:0] rp12;

    int n_checks;
    int n_errors;
    exp_t q16[$];
    exp_t q12[$];

    // Hand-computed expected sequences.
    int t1_addr[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int t1_fidx[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int t2_addr[8] = '{14, 15, 0, 1, 14, 15, 0, 1};
    int t2_fidx[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int tx_lif[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
    int tx_lf[8]   = '{0, 0, 0, 0, 1, 1, 1, 1};
    int t6_addr[6] = '{10, 11, 0, 1, 2, 3};
    int t6_fidx[6] = '{0, 0, 0, 1, 1, 1};
    int t6_lif[6]  = '{0, 0, 1, 0, 0, 1};
    int t6_lf[6]   = '{0, 0, 0, 1, 1, 1};

    filter_addr_gen #(.DEPTH(16), .MAX_FILTER_SIZE(8), .NUM_FILTERS_MAX(4), .MAX_REPEAT(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .abort(abort16),
        .cfg_base_addr(base16), .cfg_filter_size(fs16), .cfg_num_filters(nf16), .cfg_repeat(rp16),
        .addr_valid(valid16), .addr_ready(ready16), .raddr(raddr16), .filter_idx(fidx16),
        .last_in_filter(lif16), .last_filter(lf16), .busy(busy16), .done(done16), .err_cfg(err16)
    );

    filter_addr_gen #(.DEPTH(12), .MAX_FILTER_SIZE(8), .NUM_FILTERS_MAX(4), .MAX_REPEAT(16)) u_dut12 (
        .clk(clk), .rst(rst), .start(start12), .abort(abort12),
        .cfg_base_addr(base12), .cfg_filter_size(fs12), .cfg_num_filters(nf12), .cfg_repeat(rp12),
        .addr_valid(valid12), .addr_ready(ready12), .raddr(raddr12), .filter_idx(fidx12),
        .last_in_filter(lif12), .last_filter(lf12), .busy(busy12), .done(done12), .err_cfg(err12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push16(input int a, input int f, input int l1, input int l2);
        q16.push_back('{a, f, l1, l2});
    endtask

    task automatic push_basic();
        for (int i = 0; i < 8; i++) push16(t1_addr[i], t1_fidx[i], tx_lif[i], tx_lf[i]);
    endtask

    task automatic start16_run(input int base, input int fs, input int nf, input int rp);
        base16 = 4'(base); fs16 = 4'(fs); nf16 = 3'(nf); rp16 = 5'(rp);
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
    endtask

    // Pattern 0: ready always high. Pattern 1: ready 1,0,0,1,0,0,...
    task automatic wait_done16(input int pattern, input string tag);
        bit seen;
        bit prev_final;
        seen = 1'b0;
        prev_final = 1'b0;
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            ready16 = (pattern == 0) ? 1'b1 : ((cyc % 3) == 0);
            @(negedge clk);
            if (done16) begin
                seen = 1'b1;
                check({tag, "_done_after_final_xfer"}, int'(prev_final), 1);
                check({tag, "_all_xfers_seen"}, q16.size(), 0);
                check({tag, "_valid_low_in_done"}, int'(valid16), 0);
            end
            prev_final = valid16 & ready16 & lif16 & lf16;
            @(posedge clk);
            #1;
        end
        if (!seen) check({tag, "_done_timeout"}, 0, 1);
        check({tag, "_done_one_cycle"}, int'({done16, busy16, valid16}), 0);
        q16.delete();
    endtask

    task automatic bad16(input int fs, input int nf, input int rp, input string tag);
        start16_run(0, fs, nf, rp);
        check({tag, "_err_pulse"}, int'({err16, busy16, valid16}), 3'b100);
        tick();
        check({tag, "_err_cleared"}, int'({err16, busy16, valid16}), 3'b000);
    endtask

    // Monitor for the DEPTH=16 instance: scoreboard pops and stall stability.
    bit         stall16_prev;
    logic [7:0] stall16_snap;
    always @(negedge clk) begin
        exp_t e;
        if (rst && valid16) begin
            if (stall16_prev) check("stall_hold16", int'({raddr16, fidx16, lif16}), int'(stall16_snap));
            if (ready16 && !abort16) begin
                if (q16.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_xfer16: got raddr %0d expected no transfer", raddr16);
                end else begin
                    e = q16.pop_front();
                    check("xfer16_raddr", int'(raddr16), e.raddr);
                    check("xfer16_fidx", int'(fidx16), e.fidx);
                    check("xfer16_lif", int'(lif16), e.lif);
                    check("xfer16_lf", int'(lf16), e.lf);
                end
            end
        end
        stall16_prev = rst && valid16 && !ready16 && !abort16;
        stall16_snap = {raddr16, fidx16, lif16};
    end

    // Monitor for the DEPTH=12 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst && valid12 && ready12 && !abort12) begin
            if (q12.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_xfer12: got raddr %0d expected no transfer", raddr12);
            end else begin
                e = q12.pop_front();
                check("xfer12_raddr", int'(raddr12), e.raddr);
                check("xfer12_fidx", int'(fidx12), e.fidx);
                check("xfer12_lif", int'(lif12), e.lif);
                check("xfer12_lf", int'(lf12), e.lf);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen12;
        n_checks = 0; n_errors = 0;
        stall16_prev = 1'b0; stall16_snap = 8'd0;
        rst = 1'b0;
        start16 = 1'b0; abort16 = 1'b0; ready16 = 1'b0;
        base16 = 4'd0; fs16 = 4'd0; nf16 = 3'd0; rp16 = 5'd0;
        start12 = 1'b0; abort12 = 1'b0; ready12 = 1'b0;
        base12 = 4'd0; fs12 = 4'd0; nf12 = 3'd0; rp12 = 5'd0;
        #12;
        check("reset16_outputs", int'({valid16, raddr16, fidx16, lif16, lf16, busy16, done16, err16}), 0);
        check("reset12_outputs", int'({valid12, raddr12, fidx12, lif12, lf12, busy12, done12, err12}), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Test 1: basic run
        push_basic();
        start16_run(0, 4, 2, 1);
        check("t1_first_valid", int'({valid16, busy16}), 2'b11);
        wait_done16(0, "t1");

        // Test 2: wrap plus repeat
        for (int i = 0; i < 8; i++) push16(t2_addr[i], t2_fidx[i], tx_lif[i], tx_lf[i]);
        start16_run(14, 4, 1, 2);
        wait_done16(0, "t2");

        // Test 3: back-pressure
        push_basic();
        start16_run(0, 4, 2, 1);
        wait_done16(1, "t3");

        // Test 4: illegal configurations
        bad16(0, 2, 1, "fs0");
        bad16(4, 5, 1, "nf5");
        bad16(8, 3, 1, "fs8_nf3");
        bad16(4, 1, 0, "rep0");

        // start and abort together in IDLE: abort wins
        abort16 = 1'b1;
        start16_run(0, 4, 2, 1);
        abort16 = 1'b0;
        check("idle_abort_start", int'({busy16, valid16, err16}), 0);

        // Test 5a: abort after third transfer
        for (int i = 0; i < 3; i++) push16(t1_addr[i], t1_fidx[i], tx_lif[i], tx_lf[i]);
        ready16 = 1'b1;
        start16_run(0, 4, 2, 1);
        tick(); tick(); tick();
        abort16 = 1'b1;
        tick();
        abort16 = 1'b0;
        check("abort_outputs", int'({valid16, busy16, done16}), 0);
        check("abort_xfer_count", q16.size(), 0);
        tick();
        check("abort_no_done", int'(done16), 0);
        push_basic();
        start16_run(0, 4, 2, 1);
        wait_done16(0, "t5_restart");

        // Test 5b: asynchronous reset mid-run
        push16(0, 0, 0, 0);
        ready16 = 1'b1;
        start16_run(0, 4, 2, 1);
        tick();
        #1 rst = 1'b0;
        #1;
        check("midrun_reset_outputs", int'({valid16, raddr16, fidx16, lif16, lf16, busy16, done16, err16}), 0);
        check("midrun_reset_xfers", q16.size(), 0);
        q16.delete();
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_reset_no_done", int'({done16, busy16}), 0);

        // Test 6: DEPTH=12 wrap and head advance
        for (int i = 0; i < 6; i++) q12.push_back('{t6_addr[i], t6_fidx[i], t6_lif[i], t6_lf[i]});
        base12 = 4'd10; fs12 = 4'd3; nf12 = 3'd2; rp12 = 5'd1;
        ready12 = 1'b1;
        start12 = 1'b1;
        tick();
        start12 = 1'b0;
        seen12 = 1'b0;
        for (int cyc = 0; cyc < 50 && !seen12; cyc++) begin
            @(negedge clk);
            if (done12) begin
                seen12 = 1'b1;
                check("t6_all_xfers_seen", q12.size(), 0);
            end
            @(posedge clk);
            #1;
        end
        if (!seen12) check("t6_done_timeout", 0, 1);
        check("t6_idle_after_done", int'({done12, busy12, valid12}), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/filter_addr_gen.md
Name: filter_addr_gen

Overview:
- Parametrised read-address generator for the filter buffer of the convolution datapath.
- Streams the addresses of up to NUM_FILTERS_MAX filters, each cfg_filter_size rows long, out of a circular buffer of DEPTH rows.
- Each filter can be replayed cfg_repeat times before the head advances.
- Addresses leave on a valid/ready handshake to the buffer read port; done and status flags go to the main controller.

Parameters:
- DEPTH, 16, rows in filter buffer; any value >= 2, not necessarily a power of 2.
- MAX_FILTER_SIZE, 8, largest legal runtime filter size.
- NUM_FILTERS_MAX, 4, largest legal runtime filter count.
- MAX_REPEAT, 16, largest legal replay count per filter.
- ADDR_W, clog2(DEPTH), address width (derived; do not override).
- FS_W, clog2(MAX_FILTER_SIZE+1), filter-size field width.
- NF_W, clog2(NUM_FILTERS_MAX+1), filter-count field width.
- RP_W, clog2(MAX_REPEAT+1), repeat field width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; latches cfg_* when idle.
- abort  in  1  synchronous cancel of the current run.
- cfg_base_addr  in  ADDR_W  row of the first filter's head.
- cfg_filter_size  in  FS_W  rows per filter.
- cfg_num_filters  in  NF_W  number of filters.
- cfg_repeat  in  RP_W  passes per filter.
- addr_valid  out  1  raddr holds a valid address.
- addr_ready  in  1  consumer accepts raddr this cycle.
- raddr  out  ADDR_W  buffer read address.
- filter_idx  out  NF_W  index of the filter being read.
- last_in_filter  out  1  raddr is the final row of the current pass.
- last_filter  out  1  current pass is the final pass of the final filter.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse at normal completion.
- err_cfg  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE.
  - All counters, head and config registers cleared.
  - All outputs 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - Config is legal when filter_size is in 1..MAX_FILTER_SIZE, num_filters is in 1..NUM_FILTERS_MAX, repeat is in 1..MAX_REPEAT, and filter_size*num_filters <= DEPTH.
  - Legal: latch config, head<=base, idx<=0, rep<=0, fcnt<=0, go to RUN.
  - Illegal: err_cfg=1 for one cycle, stay IDLE.
- RUN:
  - addr_valid=1, raddr=(head+idx) mod DEPTH, filter_idx=fcnt.
  - Latency: start at edge t gives first valid address in the cycle after t.
- Handshake:
  - A transfer occurs when addr_valid & addr_ready.
  - Without a transfer, raddr, filter_idx and the flags hold stable.
  - One address per cycle at most; back-to-back transfers sustain full rate.
- On each transfer:
  - idx < fs-1: idx+1.
  - idx = fs-1 and rep < repeat-1: idx<=0, rep+1, head unchanged.
  - idx = fs-1, rep = repeat-1, fcnt < nf-1: idx<=0, rep<=0, fcnt+1, head<=(head+fs) mod DEPTH.
  - idx = fs-1, rep = repeat-1, fcnt = nf-1: go to DONE.
- Flags:
  - last_in_filter = (idx = fs-1).
  - last_filter = (fcnt = nf-1) & (rep = repeat-1).
  - Both are qualified by addr_valid.
- DONE: done=1 and addr_valid=0 for exactly one cycle, then IDLE.
- Wrap arithmetic:
  - Modular add computes an ADDR_W+1 bit sum and subtracts DEPTH if sum >= DEPTH.
  - No power-of-2 masking.
  - Example: base=14, DEPTH=16, fs=4 gives addresses 14,15,0,1.
- abort:
  - Takes priority over transfer and start.
  - From RUN or DONE: next state IDLE, addr_valid=0, no done pulse; an address presented in the abort cycle does not count as transferred.
  - In IDLE: abort has no effect.
- start while busy is ignored; no error pulse.
- start and abort in the same IDLE cycle: abort wins, stay IDLE.
- Reset mid-run: immediate return to the reset state; no done pulse.
- busy = 1 in RUN and DONE.

Decomposition:
- Package filter_gen_pkg:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Function clog2 and the derived-width localparams.
- One sub-module, mod_add:
  - Parametrised by DEPTH and ADDR_W.
  - Combinational (a+b) mod DEPTH for a < DEPTH and b <= DEPTH.
  - Used for both raddr and head advance.
- Counters (idx, rep, fcnt) and the head register are inline in filter_addr_gen.

Test Plan:
1. Basic run: DEPTH=16, base=0, fs=4, nf=2, repeat=1, ready=1.
   - Expect raddr 0,1,2,3,4,5,6,7 and filter_idx 0,0,0,0,1,1,1,1.
   - last_in_filter on 3 and 7; last_filter on 4..7.
   - done one cycle after the address-7 transfer.
2. Wrap plus repeat: base=14, fs=4, nf=1, repeat=2.
   - Expect raddr 14,15,0,1,14,15,0,1, then done.
3. Back-pressure: basic run with ready toggling 1,0,0,1,...
   - raddr and flags stable during stalls.
   - Exactly 8 transfers, same address order as test 1.
4. Illegal configs: fs=0; nf=5; fs=8 with nf=3 (24>16).
   - Each gives one err_cfg pulse, busy stays 0, addr_valid stays 0.
5. Abort and reset:
   - abort after the 3rd transfer: addr_valid=0 and busy=0 next cycle, no done; a fresh start then restarts from base.
   - rst low mid-run: all outputs 0 asynchronously.
6. Non-power-of-2 depth: DEPTH=12, base=10, fs=3, nf=2.
   - Expect raddr 10,11,0,1,2,3.
   - Head after the first filter is 1.
